ha_bist: RTL

Built-in self-test engine for the half-adder cell. It is the hardware counterpart of the half-adder stimulus bench. It drives the four input combinations onto a half adder, then samples the returned sum/carry and compares them with the expected values. It counts mismatches and reports pass/fail. It sits beside the `ha` instance and connects directly to its a/b inputs and sum/carry outputs.

---
 rtl/ha_bist.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ha_bist.sv
// rtl/ha_bist.sv - BIST engine sweeping the four half-adder vectors and counting mismatches
// Optional first-failure capture is built only when HA_BIST_FAIL_LOG_EN is defined.
module ha_bist #(
    parameter int HOLD_CYCLES = 1,
    parameter int LOOPS       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_o,
    output logic       b_o,
    input  logic       sum_i,
    input  logic       carry_i,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]  LOOP_LAST = 8'(LOOPS - 1);

    state_t      state;
    logic [15:0] hold_cnt;
    logic [7:0]  loop_cnt;
    logic        mismatch;
    logic [3:0]  err_next;
    logic        run_req;

    // Stimulus is the vector index itself, so it is registered and {a_o,b_o}==vec_idx always.
    assign a_o = vec_idx[1];
    assign b_o = vec_idx[0];

    assign run_req = (state == IDLE || state == DONE) && start;

    always_comb begin
        mismatch = (sum_i != (a_o ^ b_o)) || (carry_i != (a_o & b_o));
        err_next = err_cnt;
        if (mismatch && err_cnt != 4'hF) begin
            err_next = err_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            loop_cnt <= '0;
            vec_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= APPLY;
                        hold_cnt <= '0;
                        loop_cnt <= '0;
                        vec_idx  <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                    end
                end
                APPLY: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                SAMPLE: begin
                    err_cnt <= err_next;
                    if (vec_idx != 2'd3) begin
                        vec_idx <= vec_idx + 2'd1;
                        state   <= APPLY;
                    end else if (loop_cnt != LOOP_LAST) begin
                        vec_idx  <= '0;
                        loop_cnt <= loop_cnt + 8'd1;
                        state    <= APPLY;
                    end else begin
                        // pass must reflect the final sample, hence err_next rather than err_cnt.
                        vec_idx <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next == 4'd0);
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HA_BIST_FAIL_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (run_req) begin
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (state == SAMPLE && mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec_idx;
            first_fail_valid <= 1'b1;
        end
    end
`else
    logic unused_run_req;
    assign unused_run_req   = run_req;
    assign first_fail_vec   = 2'd0;
    assign first_fail_valid = 1'b0;
`endif

endmodule
